// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath width, boot/exception defaults,
// fetch FSM encoding and the IF/ID payload.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [XLEN-1:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;
  localparam logic [XLEN-1:0] NOP                = 32'h0000_0000;
  localparam logic [XLEN-1:0] WORD_MASK          = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } ifid_t;

  // Instruction addresses are always word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & WORD_MASK;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, load captures a fetched word,
// otherwise contents are held.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_inst,
  output logic            id_valid
);

  ifid_t ifid_q;
  logic  valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_q  <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      ifid_q  <= '{pc: '0, inst: NOP};
      valid_q <= 1'b0;
    end else if (load) begin
      ifid_q  <= '{pc: pc, inst: inst};
      valid_q <= 1'b1;
    end
  end

  assign id_pc    = ifid_q.pc;
  assign id_inst  = ifid_q.inst;
  assign id_valid = valid_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC sequencing with one-delay-slot branches,
// stall hold with pending-branch capture, and exception entry/return.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            ce,
  output logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] data,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            exc,
  input  logic            eret,
  input  logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_inst,
  output logic            id_valid
);

  localparam logic [XLEN-1:0] RESET_PC_A   = RESET_PC & WORD_MASK;
  localparam logic [XLEN-1:0] EXC_VECTOR_A = EXC_VECTOR & WORD_MASK;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            pend_vld_q, pend_vld_d;
  logic            ce_q, ce_d;
  logic            load_c, flush_c;

  // Next-PC selection: exc > eret > stall > branch (current, then pending) > PC+4.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    load_c     = 1'b0;
    flush_c    = 1'b0;
    if (exc) begin
      pc_d       = EXC_VECTOR_A;
      flush_c    = 1'b1;
      pend_vld_d = 1'b0;
      state_d    = RUN;
    end else if (eret) begin
      pc_d       = word_align(epc);
      flush_c    = 1'b1;
      pend_vld_d = 1'b0;
      state_d    = RUN;
    end else if (state_q == BOOT) begin
      state_d = RUN;
    end else if (stall) begin
      state_d = HOLD;
      if (br_taken) begin
        pend_d     = word_align(br_target);
        pend_vld_d = 1'b1;
      end
    end else begin
      state_d    = RUN;
      load_c     = 1'b1;
      pend_vld_d = 1'b0;
      if (br_taken) begin
        pc_d = word_align(br_target);
      end else if (pend_vld_q) begin
        pc_d = pend_q;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
    ce_d = (state_d != BOOT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC_A;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ce_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ce_q       <= ce_d;
    end
  end

  assign ce   = ce_q;
  assign addr = pc_q;

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c),
    .flush    (flush_c),
    .pc       (pc_q),
    .inst     (data),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_valid (id_valid)
  );

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h0000_0020, meaning the exception entry address.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 ce  out  1  instruction-memory chip enable.
REQ-006 addr  out  32  instruction-memory byte address (the current PC).
REQ-007 data  in  32  instruction word, valid in the same cycle as addr (combinational memory).
REQ-008 stall  in  1  hold PC and IF/ID contents.
REQ-009 br_taken  in  1  branch/jump resolved in decode, one-cycle pulse.
REQ-010 br_target  in  32  redirect address, qualified by br_taken.
REQ-011 exc  in  1  exception request, one-cycle pulse.
REQ-012 eret  in  1  exception return request, one-cycle pulse.
REQ-013 epc  in  32  return address, qualified by eret.
REQ-014 id_pc  out  32  PC of the instruction held in IF/ID.
REQ-015 id_inst  out  32  instruction held in IF/ID.
REQ-016 id_valid  out  1  IF/ID holds a real instruction.

Function
REQ-017 SHALL implement states BOOT, RUN and HOLD.
REQ-018 BOOT: ce=0 for exactly one cycle after rst_n deasserts, then unconditional transition to RUN.
REQ-019 RUN: ce=1, addr=PC; on each edge, data is captured into id_inst, PC into id_pc, and id_valid=1.
REQ-020 Fetch latency SHALL be one cycle: a word presented on addr appears on id_inst after the next edge.
REQ-021 Next-PC priority SHALL be exc > eret > stall > pending/current branch > PC+4.
REQ-022 exc SHALL load PC=EXC_VECTOR and clear id_valid, with id_inst=32'h0 (bubble), overriding stall.
REQ-023 eret SHALL load PC=epc and clear id_valid, overriding stall.
REQ-024 Branches have one delay slot: br_taken SHALL NOT flush IF/ID; the word fetched in the br_taken cycle enters IF/ID normally and PC becomes br_target.
REQ-025 stall SHALL move RUN->HOLD: PC, id_pc, id_inst and id_valid are held; ce stays 1 and addr stays at the held PC.
REQ-026 br_taken during stall SHALL latch br_target into a pending register; on stall release the PC SHALL load the pending target instead of PC+4, and the pending flag SHALL then clear.
REQ-027 A second br_taken while a branch is pending SHALL overwrite the pending target.
REQ-028 exc or eret SHALL clear any pending branch.
REQ-029 HOLD->RUN SHALL occur on the first cycle with stall=0.
REQ-030 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) without error.
REQ-031 addr[1:0] SHALL always be 2'b00; br_target, epc and the parameters SHALL be used with bits [1:0] forced to 0.

Reset
REQ-032 While rst_n=0: state=BOOT, PC=RESET_PC, ce=0, addr=RESET_PC, id_pc=0, id_inst=0, id_valid=0, pending flag=0.
REQ-033 Reset assertion mid-fetch SHALL take effect immediately (asynchronously) on all registers, discarding any pending branch.

Structure
REQ-034 RESET_PC and EXC_VECTOR defaults, the state encoding and the NOP constant (32'h0) SHALL live in shared package cpu_pkg.
REQ-035 IF/ID pipeline register SHALL be sub-module if_id_reg (inputs: load, flush; outputs: id_pc, id_inst, id_valid).

Verification
REQ-036 Release reset with ROM word0=32'h0000f025 and word1=32'h241d1000 -> ce=0 for one cycle; then addr=0, then addr=4; id_inst=32'h0000f025 with id_pc=0 and id_valid=1, followed by 32'h241d1000.
REQ-037 br_taken with br_target=32'h0000_0144 while addr=32'h0000_0100 -> the next IF/ID holds the word at 0x100 (delay slot), and the following addr is 0x144.
REQ-038 stall held for 3 cycles at addr=0x40 with a br_taken(0x200) pulse in cycle 2 -> PC and IF/ID are frozen for 3 cycles; after release addr=0x200 rather than 0x44.
REQ-039 exc asserted together with stall at addr=0x80 -> next addr=0x20 and id_valid=0; then eret with epc=0x84 -> addr=0x84 and id_valid=0 for one cycle.
REQ-040 PC forced to 32'hFFFF_FFFC -> next addr=0; and rst_n pulsed low mid-HOLD with a branch pending -> all outputs return to their reset values, and the pending branch is never applied.
